// File: rtl/mem_wb_stage.sv
// Memory-access stage with MEM/WB pipeline register feeding the 14-entry register file.
// Optional MEM_TIMEOUT_EN adds a wait-state watchdog and a sticky mem_err flag.
module mem_wb_stage #(
   parameter int BASE_ADDR   = 1024,
   parameter int ADDR_W      = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic              WB_EN,
   input  logic              MEM_R_EN,
   input  logic              MEM_W_EN,
   input  logic [31:0]       ALU_res,
   input  logic [31:0]       Val_Rm,
   input  logic [3:0]        Dest,
   output logic              freeze,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [3:0]        Dest_wb,
   output logic [31:0]       Result_WB,
   output logic              writeBackEn,
   output logic              mem_err
);

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   state_t            state;
   state_t            state_next;

   logic              capture;
   logic              alu_retire;
   logic              finish_access;

   logic [ADDR_W-1:0] cap_addr;
   logic [31:0]       cap_wdata;
   logic [3:0]        cap_dest;
   logic              cap_wb_en;
   logic              cap_read;

   logic [31:0]       byte_off;
   logic              dest_ok;
   logic              unused_bits;

   // Register file only has entries 0-13; writes to 14/15 are dropped here.
   assign byte_off    = ALU_res - 32'(BASE_ADDR);
   assign dest_ok     = (Dest < 4'd14);
   assign unused_bits = ^{byte_off[1:0], byte_off[31:ADDR_W+2]};

   assign freeze    = (state == ACCESS);
   assign mem_req   = (state == ACCESS);
   assign mem_we    = (state == ACCESS) && !cap_read;
   assign mem_addr  = cap_addr;
   assign mem_wdata = cap_wdata;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             timed_out;
   logic             err_q;

   assign mem_err = err_q;
`else
   logic unused_timeout;

   assign unused_timeout = (MEM_TIMEOUT != 0);
   assign mem_err        = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next    = state;
      capture       = 1'b0;
      alu_retire    = 1'b0;
      finish_access = 1'b0;
`ifdef MEM_TIMEOUT_EN
      timed_out     = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (valid) begin
               if (MEM_R_EN || MEM_W_EN) begin
                  capture    = 1'b1;
                  state_next = ACCESS;
               end else begin
                  alu_retire = 1'b1;
               end
            end
         end
         ACCESS: begin
            // A ready in the same cycle as the watchdog expiry still completes the access.
            if (mem_ready) begin
               finish_access = 1'b1;
               state_next    = IDLE;
            end
`ifdef MEM_TIMEOUT_EN
            else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
               timed_out  = 1'b1;
               state_next = IDLE;
            end
`endif
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_addr  <= '0;
         cap_wdata <= '0;
         cap_dest  <= '0;
         cap_wb_en <= 1'b0;
         cap_read  <= 1'b0;
      end else if (capture) begin
         cap_addr  <= byte_off[ADDR_W+1:2];
         cap_wdata <= Val_Rm;
         cap_dest  <= Dest;
         cap_wb_en <= WB_EN && dest_ok;
         cap_read  <= MEM_R_EN;
      end
   end

   // writeBackEn defaults low so every retirement is a single-cycle pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         Dest_wb     <= '0;
         Result_WB   <= '0;
         writeBackEn <= 1'b0;
      end else begin
         writeBackEn <= 1'b0;
         if (alu_retire) begin
            Dest_wb     <= Dest;
            Result_WB   <= ALU_res;
            writeBackEn <= WB_EN && dest_ok;
         end else if (finish_access && cap_read) begin
            Dest_wb     <= cap_dest;
            Result_WB   <= mem_rdata;
            writeBackEn <= cap_wb_en;
         end
      end
   end

`ifdef MEM_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (capture) begin
            wait_cnt <= '0;
         end else if ((state == ACCESS) && !mem_ready) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
         end
         if (timed_out) begin
            err_q <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized bench for mem_wb_stage with a transaction-level reference model.
// Build with MEM_TIMEOUT_EN defined to also exercise the watchdog.
module tb_mem_wb_stage;

   logic        clk;
   logic        rst;
   logic        valid;
   logic        WB_EN;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic [31:0] ALU_res;
   logic [31:0] Val_Rm;
   logic [3:0]  Dest;
   logic        freeze;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [3:0]  Dest_wb;
   logic [31:0] Result_WB;
   logic        writeBackEn;
   logic        mem_err;

   int          checkCount = 0;
   int          passCount  = 0;

   logic [3:0]  modelDest   = '0;
   logic [31:0] modelResult = '0;

   mem_wb_stage #(
      .BASE_ADDR  (1024),
      .ADDR_W     (16),
      .MEM_TIMEOUT(15)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .valid      (valid),
      .WB_EN      (WB_EN),
      .MEM_R_EN   (MEM_R_EN),
      .MEM_W_EN   (MEM_W_EN),
      .ALU_res    (ALU_res),
      .Val_Rm     (Val_Rm),
      .Dest       (Dest),
      .freeze     (freeze),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .Dest_wb    (Dest_wb),
      .Result_WB  (Result_WB),
      .writeBackEn(writeBackEn),
      .mem_err    (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Word index into data memory: byte offset from the base, divided by four.
   function automatic logic [15:0] wordAddr(input logic [31:0] byteAddr);
      logic [31:0] offset;
      offset = (byteAddr - 32'd1024) / 32'd4;
      return offset[15:0];
   endfunction

   function automatic logic writesRegfile(input logic wb, input logic [3:0] dst);
      return wb && (dst <= 4'd13);
   endfunction

   task automatic scrambleExeInputs();
      WB_EN    = 1'($urandom);
      MEM_R_EN = 1'($urandom);
      MEM_W_EN = 1'($urandom);
      ALU_res  = $urandom;
      Val_Rm   = $urandom;
      Dest     = 4'($urandom);
   endtask

   // Issue one instruction from IDLE, serve its memory access with the given
   // number of wait states, then spend one idle cycle checking the pulse ended.
   task automatic applyStimulus(input logic rEn, input logic wEn, input logic wb,
                                input logic [31:0] alu, input logic [31:0] rm,
                                input logic [3:0] dst, input int waits,
                                input logic [31:0] rdata);
      logic isMem;
      logic isLoad;
      logic expWbe;
      isMem  = rEn || wEn;
      isLoad = rEn;
      valid    = 1'b1;
      WB_EN    = wb;
      MEM_R_EN = rEn;
      MEM_W_EN = wEn;
      ALU_res  = alu;
      Val_Rm   = rm;
      Dest     = dst;
      checkOutput("freeze_before_issue", 32'(freeze), 32'd0);
      @(posedge clk); #1;
      if (!isMem) begin
         modelDest   = dst;
         modelResult = alu;
         expWbe      = writesRegfile(wb, dst);
         checkOutput("alu_wbe", 32'(writeBackEn), 32'(expWbe));
         checkOutput("alu_dest", 32'(Dest_wb), 32'(modelDest));
         checkOutput("alu_result", Result_WB, modelResult);
         checkOutput("alu_freeze", 32'(freeze), 32'd0);
         checkOutput("alu_mem_req", 32'(mem_req), 32'd0);
      end else begin
         scrambleExeInputs();
         valid = 1'b1;
         for (int c = 0; c <= waits; c++) begin
            checkOutput("acc_freeze", 32'(freeze), 32'd1);
            checkOutput("acc_mem_req", 32'(mem_req), 32'd1);
            checkOutput("acc_mem_we", 32'(mem_we), 32'(!isLoad));
            checkOutput("acc_mem_addr", 32'(mem_addr), 32'(wordAddr(alu)));
            checkOutput("acc_mem_wdata", mem_wdata, rm);
            checkOutput("acc_wbe", 32'(writeBackEn), 32'd0);
            mem_ready = (c == waits);
            mem_rdata = (c == waits) ? rdata : $urandom;
            @(posedge clk); #1;
            scrambleExeInputs();
         end
         mem_ready = 1'b0;
         valid     = 1'b0;
         if (isLoad) begin
            modelDest   = dst;
            modelResult = rdata;
            expWbe      = writesRegfile(wb, dst);
         end else begin
            expWbe = 1'b0;
         end
         checkOutput("done_freeze", 32'(freeze), 32'd0);
         checkOutput("done_mem_req", 32'(mem_req), 32'd0);
         checkOutput("done_wbe", 32'(writeBackEn), 32'(expWbe));
         checkOutput("done_dest", 32'(Dest_wb), 32'(modelDest));
         checkOutput("done_result", Result_WB, modelResult);
      end
      valid = 1'b0;
      scrambleExeInputs();
      mem_ready = 1'($urandom);
      mem_rdata = $urandom;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      checkOutput("idle_wbe", 32'(writeBackEn), 32'd0);
      checkOutput("idle_dest_hold", 32'(Dest_wb), 32'(modelDest));
      checkOutput("idle_result_hold", Result_WB, modelResult);
      checkOutput("idle_freeze", 32'(freeze), 32'd0);
      checkOutput("idle_mem_err", 32'(mem_err), 32'd0);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_freeze"}, 32'(freeze), 32'd0);
      checkOutput({tag, "_mem_req"}, 32'(mem_req), 32'd0);
      checkOutput({tag, "_wbe"}, 32'(writeBackEn), 32'd0);
      checkOutput({tag, "_dest"}, 32'(Dest_wb), 32'd0);
      checkOutput({tag, "_result"}, Result_WB, 32'd0);
      checkOutput({tag, "_mem_err"}, 32'(mem_err), 32'd0);
   endtask

   initial begin
      int kind;
      rst       = 1'b1;
      valid     = 1'b0;
      WB_EN     = 1'b0;
      MEM_R_EN  = 1'b0;
      MEM_W_EN  = 1'b0;
      ALU_res   = '0;
      Val_Rm    = '0;
      Dest      = '0;
      mem_rdata = '0;
      mem_ready = 1'b0;
      #2;
      checkAllZero("reset");
      checkOutput("reset_mem_addr", 32'(mem_addr), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      $display("[TB] directed cases");
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_00AA, 32'h0, 4'd3, 0, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'd1032, 32'h5555_0000, 4'd5, 2, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 1'b1, 1'b1, 32'd1028, 32'h0000_1234, 4'd7, 0, 32'hFFFF_FFFF);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0777, 32'h0, 4'd14, 0, 32'h0);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'd2048, 32'hAAAA_5555, 4'd9, 1, 32'hCAFE_F00D);
      applyStimulus(1'b1, 1'b0, 1'b1, 32'd1036, 32'h0, 4'd15, 0, 32'h1111_2222);

      $display("[TB] reset during access");
      valid    = 1'b1;
      WB_EN    = 1'b1;
      MEM_R_EN = 1'b1;
      MEM_W_EN = 1'b0;
      ALU_res  = 32'd1040;
      Dest     = 4'd2;
      @(posedge clk); #1;
      valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("pre_reset_mem_req", 32'(mem_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      checkAllZero("mid_reset");
      #3 rst = 1'b0;
      modelDest   = '0;
      modelResult = '0;
      @(posedge clk); #1;
      checkOutput("post_reset_freeze", 32'(freeze), 32'd0);
      checkOutput("post_reset_wbe", 32'(writeBackEn), 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0BAD_C0DE, 32'h0, 4'd1, 0, 32'h0);

      $display("[TB] random instruction stream");
      for (int i = 0; i < 150; i++) begin
         kind = $urandom_range(0, 3);
         applyStimulus((kind == 1) || (kind == 3), (kind == 2) || (kind == 3),
                       1'($urandom), $urandom, $urandom, 4'($urandom),
                       $urandom_range(0, 4), $urandom);
      end

`ifdef MEM_TIMEOUT_EN
      $display("[TB] timeout case");
      valid    = 1'b1;
      WB_EN    = 1'b1;
      MEM_R_EN = 1'b1;
      MEM_W_EN = 1'b0;
      ALU_res  = 32'd1100;
      Dest     = 4'd6;
      @(posedge clk); #1;
      valid     = 1'b0;
      mem_ready = 1'b0;
      for (int c = 0; c < 15; c++) begin
         checkOutput("to_freeze", 32'(freeze), 32'd1);
         checkOutput("to_wbe", 32'(writeBackEn), 32'd0);
         @(posedge clk); #1;
      end
      checkOutput("to_exit_freeze", 32'(freeze), 32'd0);
      checkOutput("to_exit_wbe", 32'(writeBackEn), 32'd0);
      checkOutput("to_mem_err", 32'(mem_err), 32'd1);
      @(posedge clk); #1;
      checkOutput("to_mem_err_sticky", 32'(mem_err), 32'd1);
      checkOutput("to_dest_hold", 32'(Dest_wb), 32'(modelDest));
`endif

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
